// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// The optional auto-repeat feature in keypad_scan is enabled with KEY_REPEAT_EN.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int ROW_W   = 2;
    localparam int COL_W   = 2;

    localparam logic [KP_ROWS-1:0] ROW_IDLE = 4'b1111;
    localparam logic [KP_COLS-1:0] COL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    // Lowest-index column that is pulled low; 0 when none is low.
    function automatic logic [COL_W-1:0] lowest_low_col(input logic [KP_COLS-1:0] cols);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = KP_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

    // Active-low one-hot drive pattern for a row index.
    function automatic logic [KP_ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
        logic [KP_ROWS-1:0] drive;
        drive      = ROW_IDLE;
        drive[row] = 1'b0;
        return drive;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-step tick divider: one-clk pulse every CLK_FREQ/1000*SCAN_MS cycles.
// A synchronous clear holds the divider at zero and suppresses the tick.
module keypad_tick_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned SCAN_MS  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV  = CLK_FREQ / 1000 * SCAN_MS;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounce and key reporting.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned SCAN_MS         = 1,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [KP_COLS-1:0] key_col,
    output logic [KP_ROWS-1:0] key_row,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held
);

    localparam int unsigned DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_MS - 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY_MS + 1);
    localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
    logic [RW-1:0] rep_q, rep_d;
`endif

    logic                tick;
    logic [KP_COLS-1:0]  col_meta_q, col_sync_q;
    kp_state_e           state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [KP_COLS-1:0]  pat_q, pat_d;
    logic [DW-1:0]       deb_q, deb_d;
    logic [KP_ROWS-1:0]  key_row_q, key_row_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    keypad_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .SCAN_MS  (SCAN_MS)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= COL_IDLE;
            col_sync_q <= COL_IDLE;
        end else begin
            col_meta_q <= key_col;
            col_sync_q <= col_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pat_d       = pat_q;
        deb_d       = deb_q;
        key_row_d   = key_row_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (!en) begin
            state_d    = SCAN;
            row_d      = '0;
            deb_d      = '0;
            key_row_d  = ROW_IDLE;
            key_held_d = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_d      = '0;
`endif
        end else if (key_row_q == ROW_IDLE) begin
            // First clk after en rises: start driving from the reset row.
            key_row_d = row_drive(row_q);
        end else if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_sync_q == COL_IDLE) begin
                        row_d     = row_q + 1'b1;
                        key_row_d = row_drive(row_q + 1'b1);
                    end else begin
                        pat_d   = col_sync_q;
                        deb_d   = '0;
                        state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (col_sync_q != pat_q) begin
                        state_d = SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        state_d     = PRESSED;
                        key_code_d  = {row_q, lowest_low_col(pat_q)};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (col_sync_q == COL_IDLE) begin
                        state_d = DEB_REL;
                        deb_d   = '0;
`ifdef KEY_REPEAT_EN
                        rep_d   = '0;
                    end else if (rep_q == REP_FIRE) begin
                        key_valid_d = 1'b1;
                        rep_d       = REP_RELOAD;
                    end else begin
                        rep_d = rep_q + 1'b1;
`endif
                    end
                end
                DEB_REL: begin
                    if (col_sync_q != COL_IDLE) begin
                        // Release bounce: back to held without re-reporting the key.
                        state_d = PRESSED;
                    end else if (deb_q == DEB_LAST) begin
                        state_d    = SCAN;
                        key_held_d = 1'b0;
                        row_d      = row_q + 1'b1;
                        key_row_d  = row_drive(row_q + 1'b1);
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            row_q       <= '0;
            pat_q       <= COL_IDLE;
            deb_q       <= '0;
            key_row_q   <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            deb_q       <= deb_d;
            key_row_q   <= key_row_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign key_row   = key_row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a switch-matrix keypad model (1 tick = 10 clk, debounce 3 ticks).
// Repeat expectations follow KEY_REPEAT_EN when the bench is built with it.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys;

    int unsigned vec_cnt   = 0;
    int unsigned miss_cnt  = 0;
    int unsigned valid_cnt = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .CLK_FREQ        (10_000),
        .SCAN_MS         (1),
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed switch (r,c) ties column c to row r; a driven-low row pulls it low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt++;
            $display("key_valid: code=%0d held=%0b at %0t", key_code, key_held, $time);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_row(input string tag, input logic [3:0] exp, input int max, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (key_row !== exp && n < max);
        check(tag, int'(key_row), int'(exp));
    endtask

    task automatic wait_valid(input string tag, input int max, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (key_valid !== 1'b1 && n < max);
        check(tag, int'(key_valid), 1);
    endtask

    task automatic wait_unheld(input string tag, input int max, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (key_held !== 1'b0 && n < max);
        check(tag, int'(key_held), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  seq [4];
        int          n;
        int unsigned v0;
        int          pulses;
        int          bad_slots;
        int          exp_pulses;
        logic        exp_v;

        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0;
        en    = 1'b1;
        keys  = '0;
        repeat (3) @(negedge clk);
        check("reset key_row", int'(key_row), 4'b1110);
        check("reset key_code", int'(key_code), 0);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_held", int'(key_held), 0);
        rst_n = 1'b1;

        // 1: idle scan, one row step per tick
        for (int i = 0; i < 4; i++) begin
            wait_row("idle row step", seq[i], 20, n);
            check("idle row dwell", n, 10);
        end
        check("idle no key_valid", int'(valid_cnt), 0);

        // 2: row2/col1 press, held ~100 clk
        v0 = valid_cnt;
        keys[9] = 1'b1;
        wait_row("press2 reach row2", 4'b1011, 30, n);
        check("press2 row2 time", n, 20);
        wait_valid("press2 valid", 80, n);
        check("press2 latency", n, 40);
        check("press2 key_code", int'(key_code), 9);
        check("press2 key_held", int'(key_held), 1);
        repeat (60) @(negedge clk);
        keys = '0;
        wait_unheld("press2 release", 80, n);
        check("press2 release time", n, 40);
        check("press2 row advance", int'(key_row), 4'b0111);
        check("press2 one valid", int'(valid_cnt - v0), 1);

        // 3: one-tick glitch on row0
        v0 = valid_cnt;
        wait_row("glitch reach row0", 4'b1110, 20, n);
        keys[0] = 1'b1;
        repeat (12) @(negedge clk);
        keys = '0;
        wait_row("glitch resume row1", 4'b1101, 40, n);
        check("glitch row hold time", n, 18);
        check("glitch no valid", int'(valid_cnt - v0), 0);
        check("glitch not held", int'(key_held), 0);

        // 4: two columns in row1, bouncy release
        v0 = valid_cnt;
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        wait_valid("multi valid", 80, n);
        check("multi latency", n, 40);
        check("multi key_code", int'(key_code), 4);
        repeat (10) @(negedge clk);
        keys = '0;
        repeat (12) @(negedge clk);
        keys[4] = 1'b1;
        repeat (10) @(negedge clk);
        keys = '0;
        wait_unheld("bounce release", 80, n);
        check("bounce release time", n, 38);
        check("bounce one valid", int'(valid_cnt - v0), 1);

        // 5: en dropped while a key is held
        v0 = valid_cnt;
        keys[9] = 1'b1;
        wait_valid("en test valid", 80, n);
        check("en test key_code", int'(key_code), 9);
        repeat (15) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en low key_row", int'(key_row), 4'b1111);
        check("en low key_held", int'(key_held), 0);
        check("en low key_valid", int'(key_valid), 0);
        check("en low key_code", int'(key_code), 9);
        keys = '0;
        repeat (20) @(negedge clk);
        check("en low rows stay idle", int'(key_row), 4'b1111);
        check("en low no extra valid", int'(valid_cnt - v0), 1);
        en = 1'b1;
        @(negedge clk);
        check("en rise key_row", int'(key_row), 4'b1110);
        wait_row("en rise first step", 4'b1101, 20, n);
        check("en rise first dwell", int'(n >= 9 && n <= 10), 1);

        // 6: long hold on row0/col2; repeats only with KEY_REPEAT_EN
        keys[2] = 1'b1;
        wait_valid("hold valid", 100, n);
        check("hold latency", n, 70);
        check("hold key_code", int'(key_code), 2);
        pulses    = 0;
        bad_slots = 0;
`ifdef KEY_REPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 0;
`endif
        for (int k = 1; k <= 125; k++) begin
            @(negedge clk);
`ifdef KEY_REPEAT_EN
            exp_v = (k == 50 || k == 70 || k == 90 || k == 110);
`else
            exp_v = 1'b0;
`endif
            if (key_valid) pulses++;
            if (key_valid !== exp_v) bad_slots++;
        end
        check("hold repeat count", pulses, exp_pulses);
        check("hold repeat timing", bad_slots, 0);
        check("hold still held", int'(key_held), 1);

        // 7: reset while the key is still down
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset key_row", int'(key_row), 4'b1110);
        check("midreset key_code", int'(key_code), 0);
        check("midreset key_valid", int'(key_valid), 0);
        check("midreset key_held", int'(key_held), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("post-reset valid", 80, n);
        check("post-reset latency", n, 40);
        check("post-reset key_code", int'(key_code), 2);
        keys = '0;
        wait_unheld("post-reset release", 80, n);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
